// File: rtl/comp_arb.sv
// Round-robin arbiter sharing one comp datapath among n_req requesters.
// Define COMP_ARB_TIMEOUT_EN to enable the WAIT-state watchdog abort.
module comp_arb #(
    parameter int p_size    = 12,
    parameter int n_req     = 4,
    parameter int p_timeout = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_req-1:0]          req_valid,
    output logic [n_req-1:0]          req_ready,
    input  logic [n_req*p_size-1:0]   req_a,
    input  logic [n_req*p_size-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2:0]                rsp_id,
    output logic [2*p_size-1:0]       rsp_data,
    output logic [2*p_size-1:0]       rsp_data_2,
    output logic                      rsp_err,
    output logic [p_size-1:0]         comp_i_param,
    output logic [p_size-1:0]         comp_i_param_2,
    output logic                      comp_ena,
    input  logic [2*p_size-1:0]       comp_o_param,
    input  logic [2*p_size-1:0]       comp_o_param_2,
    input  logic                      comp_dv
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    if (n_req < 2 || n_req > 8 || p_timeout < 1) begin : g_param_check
        $error("comp_arb: n_req must be 2..8 and p_timeout at least 1");
    end

    logic [1:0]          r_state;
    logic [1:0]          w_state_d;
    logic [2:0]          r_last_grant;
    logic [2:0]          r_winner;
    logic [p_size-1:0]   r_op_a;
    logic [p_size-1:0]   r_op_b;
    logic [2*p_size-1:0] r_rsp_data;
    logic [2*p_size-1:0] r_rsp_data_2;

    logic                w_any;
    logic [2:0]          w_grant;
    logic [p_size-1:0]   w_op_a;
    logic [p_size-1:0]   w_op_b;
    logic                w_capture;
    int                  w_dist;
    int                  w_best;

    // Winner is the valid requester with the smallest distance past last_grant.
    always_comb begin
        w_grant = 3'd0;
        w_best  = n_req;
        w_dist  = 0;
        for (int k = 0; k < n_req; k++) begin
            w_dist = (k + 2 * n_req - 1 - int'(r_last_grant)) % n_req;
            if (req_valid[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_grant = 3'(k);
            end
        end
    end

    assign w_any = |req_valid;

    always_comb begin
        w_op_a    = '0;
        w_op_b    = '0;
        req_ready = '0;
        for (int k = 0; k < n_req; k++) begin
            if (w_grant == 3'(k)) begin
                w_op_a = req_a[k*p_size +: p_size];
                w_op_b = req_b[k*p_size +: p_size];
            end
            req_ready[k] = (r_state == StIdle) && req_valid[k] && (w_grant == 3'(k));
        end
    end

`ifdef COMP_ARB_TIMEOUT_EN
    localparam int WdW = $clog2(p_timeout + 1);
    logic [WdW-1:0] r_wdog;
    logic           r_rsp_err;
    logic           w_expire;
`endif

    always_comb begin
        w_state_d = r_state;
        w_capture = 1'b0;
`ifdef COMP_ARB_TIMEOUT_EN
        w_expire  = 1'b0;
`endif
        case (r_state)
            StIdle:  if (w_any) w_state_d = StIssue;
            StIssue: w_state_d = StWait;
            StWait: begin
                if (comp_dv) begin
                    w_state_d = StResp;
                    w_capture = 1'b1;
                end
`ifdef COMP_ARB_TIMEOUT_EN
                else if (r_wdog == WdW'(p_timeout - 1)) begin
                    w_state_d = StResp;
                    w_expire  = 1'b1;
                end
`endif
            end
            StResp:  if (rsp_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_last_grant <= 3'(n_req - 1);
            r_winner     <= 3'd0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_rsp_data   <= '0;
            r_rsp_data_2 <= '0;
        end else begin
            r_state <= w_state_d;
            if ((r_state == StIdle) && w_any) begin
                r_winner <= w_grant;
                r_op_a   <= w_op_a;
                r_op_b   <= w_op_b;
            end
            if (w_capture) begin
                r_rsp_data   <= comp_o_param;
                r_rsp_data_2 <= comp_o_param_2;
            end
`ifdef COMP_ARB_TIMEOUT_EN
            else if (w_expire) begin
                r_rsp_data   <= '0;
                r_rsp_data_2 <= '0;
            end
`endif
            if ((r_state == StResp) && rsp_ready) begin
                r_last_grant <= r_winner;
            end
        end
    end

`ifdef COMP_ARB_TIMEOUT_EN
    // Counts WAIT cycles without comp_dv; cleared while issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == StIssue) begin
                r_wdog <= '0;
            end else if ((r_state == StWait) && !comp_dv) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_capture) begin
                r_rsp_err <= 1'b0;
            end else if (w_expire) begin
                r_rsp_err <= 1'b1;
            end
        end
    end
    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign comp_ena       = (r_state == StIssue);
    assign comp_i_param   = r_op_a;
    assign comp_i_param_2 = r_op_b;
    assign rsp_valid      = (r_state == StResp);
    assign rsp_id         = r_winner;
    assign rsp_data       = r_rsp_data;
    assign rsp_data_2     = r_rsp_data_2;

endmodule
